// File: rtl/cla_sum_pipe_if.sv
// Stream interface between the P/G front end, the carry-resolve pipeline and the ALU result mux.
// A beat moves on a rising clk edge exactly when valid && ready; the producer holds valid and data until then.
interface cla_sum_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] G;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, P, G, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, P, G, cin, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface

// File: rtl/cla_sum_pipe.sv
// Pipelined carry resolver: one SLICE-bit lookahead group per stage, carries ripple stage to stage.
// Registered sum/cout/ovf; per-stage ready so bubbles collapse and the pipe holds NSTG+1 beats.
module cla_sum_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic           clk,
  input logic           rst_n,
  cla_sum_pipe_if.slave bus
);
  localparam int NSTG = WIDTH / SLICE;

  logic [NSTG-1:0]  vld_q;
  logic [NSTG-1:0]  cy_q;
  logic [WIDTH-1:0] p_q [NSTG];
  logic [WIDTH-1:0] g_q [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];

  logic             out_valid_q;
  logic [WIDTH-1:0] s_out_q;
  logic             cout_q;
  logic             ovf_q;

  logic [NSTG:0]    rdy;
  logic [SLICE:0]   cv    [NSTG];
  logic [WIDTH-1:0] s_res [NSTG];

  // Flat sum-of-products lookahead: every c[i+1] is built directly from c0, G and P,
  // never from the previous carry, so depth stays two-level across the slice.
  function automatic logic [SLICE:0] lookahead(input logic [SLICE-1:0] p,
                                               input logic [SLICE-1:0] g,
                                               input logic             c0);
    logic [SLICE:0] c;
    logic           t;
    logic           acc;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SLICE; i++) begin
      t = c0;
      for (int m = 0; m <= i; m++) t = t & p[m];
      acc = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  // ready_k reduces to: output can take data, or some stage at or after k is empty.
  always_comb begin
    logic full;
    rdy = '0;
    rdy[NSTG] = !out_valid_q || bus.out_ready;
    for (int k = 0; k < NSTG; k++) begin
      full = 1'b1;
      for (int j = k; j < NSTG; j++) full = full & vld_q[j];
      rdy[k] = rdy[NSTG] || !full;
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      cv[k]    = lookahead(p_q[k][k*SLICE +: SLICE], g_q[k][k*SLICE +: SLICE], cy_q[k]);
      s_res[k] = s_q[k];
      s_res[k][k*SLICE +: SLICE] = p_q[k][k*SLICE +: SLICE] ^ cv[k][SLICE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      cy_q        <= '0;
      for (int k = 0; k < NSTG; k++) begin
        p_q[k] <= '0;
        g_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      s_out_q     <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (rdy[0]) begin
        vld_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          p_q[0]  <= bus.P;
          g_q[0]  <= bus.G;
          s_q[0]  <= '0;
          cy_q[0] <= bus.cin;
        end
      end
      for (int k = 1; k < NSTG; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            p_q[k]  <= p_q[k-1];
            g_q[k]  <= g_q[k-1];
            s_q[k]  <= s_res[k-1];
            cy_q[k] <= cv[k-1][SLICE];
          end
        end
      end
      // Carry into the MSB is the last slice's internal carry at position SLICE-1.
      if (rdy[NSTG]) begin
        out_valid_q <= vld_q[NSTG-1];
        if (vld_q[NSTG-1]) begin
          s_out_q <= s_res[NSTG-1];
          cout_q  <= cv[NSTG-1][SLICE];
          ovf_q   <= cv[NSTG-1][SLICE-1] ^ cv[NSTG-1][SLICE];
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_out_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
